// File: rtl/game_pkg.sv
// Shared game constants and types.
// Holds screen geometry, default sprite sizes, the saturated score value,
// the collision/scoring FSM encoding and the BCD digit type.
package game_pkg;

    localparam int unsigned SCREEN_W      = 1024;
    localparam int unsigned SCREEN_H      = 768;

    localparam int unsigned MISSILE_W_DEF = 4;
    localparam int unsigned MISSILE_H_DEF = 16;
    localparam int unsigned ENEMY_W_DEF   = 64;
    localparam int unsigned ENEMY_H_DEF   = 48;

    localparam logic [15:0] MAX_SCORE_BCD = 16'h9999;

    typedef enum logic [2:0] {
        StIdle,
        StCapture,
        StCompare,
        StScore,
        StLevel
    } state_e;

    typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder.
// Ports:
//   a    - BCD digit (0..9)
//   b    - binary addend (0..9)
//   cin  - carry in
//   sum  - resulting BCD digit
//   cout - decimal carry out
module bcd_digit_add
    import game_pkg::*;
(
    input  bcd_digit_t a,
    input  logic [3:0] b,
    input  logic       cin,
    output bcd_digit_t sum,
    output logic       cout
);

    logic [4:0] raw;

    always_comb begin
        raw  = {1'b0, a} + {1'b0, b} + {4'd0, cin};
        sum  = raw[3:0];
        cout = 1'b0;
        if (raw > 5'd9) begin
            sum  = 4'(raw - 5'd10);
            cout = 1'b1;
        end
    end

endmodule

// File: rtl/hit_score_ctl.sv
// Per-frame collision and scoring controller.
// On each rising edge of vblnk the FSM captures missile/enemy positions,
// tests for bounding-box overlap, ripple-adds POINTS into a 4-digit BCD
// score (one digit per cycle, saturating at 9999) and advances the level
// every HITS_PER_LEVEL hits.
// Ports:
//   pclk, rst              - clock, synchronous active-high reset
//   vblnk                  - vertical blank
//   missile_x/y, missile_on, enemy_x/y, enemy_alive - object state
//   player_hit             - enemy reached ship (lives feature only)
//   hit, level_up          - one-cycle pulses
//   score_bcd, level       - score (4 BCD digits) and current level
//   lives, game_over       - remaining lives, sticky end flag
//   busy                   - FSM not idle
// Optional feature: define HIT_SCORE_LIVES_EN to enable lives/game_over.
module hit_score_ctl
    import game_pkg::*;
#(
    parameter int unsigned MISSILE_W      = MISSILE_W_DEF,
    parameter int unsigned MISSILE_H      = MISSILE_H_DEF,
    parameter int unsigned ENEMY_W        = ENEMY_W_DEF,
    parameter int unsigned ENEMY_H        = ENEMY_H_DEF,
    parameter int unsigned POINTS         = 5,
    parameter int unsigned HITS_PER_LEVEL = 8,
    parameter int unsigned MAX_LEVEL      = 9
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vblnk,
    input  logic [11:0] missile_x,
    input  logic [11:0] missile_y,
    input  logic        missile_on,
    input  logic [11:0] enemy_x,
    input  logic [11:0] enemy_y,
    input  logic        enemy_alive,
    input  logic        player_hit,
    output logic        hit,
    output logic [15:0] score_bcd,
    output logic [3:0]  level,
    output logic        level_up,
    output logic [1:0]  lives,
    output logic        game_over,
    output logic        busy
);

    localparam int unsigned CntW = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;

    state_e      state_q, state_d;
    logic        vblnk_q;
    logic        tick;
    logic [11:0] mx_q, my_q, ex_q, ey_q;
    logic        on_q, alive_q;
    logic        overlap;
    logic [1:0]  digit_idx_q;
    logic        carry_q;
    logic        sat_q;
    logic [15:0] score_q;
    logic        hit_q;
    logic [3:0]  level_q;
    logic        level_up_q;
    logic [CntW-1:0] hit_cnt_q;
    logic [1:0]  lives_q;
    logic        game_over_q;

    bcd_digit_t  dig_a, dig_sum;
    logic [3:0]  dig_b;
    logic        dig_cout;

    assign tick = vblnk & ~vblnk_q;

    // 13-bit sums so sprite extents near 4095 cannot wrap.
    always_comb begin
        overlap = ({1'b0, mx_q} < ({1'b0, ey_q[11:0]} & 13'd0) + {1'b0, ex_q} + 13'(ENEMY_W))
                && (({1'b0, mx_q} + 13'(MISSILE_W)) > {1'b0, ex_q})
                && ({1'b0, my_q} < ({1'b0, ey_q} + 13'(ENEMY_H)))
                && (({1'b0, my_q} + 13'(MISSILE_H)) > {1'b0, ey_q})
                && on_q && alive_q;
    end

    always_comb begin
        dig_a = score_q[{digit_idx_q, 2'b00} +: 4];
        dig_b = (digit_idx_q == 2'd0) ? 4'(POINTS) : 4'd0;
    end

    bcd_digit_add u_bcd_digit_add (
        .a    (dig_a),
        .b    (dig_b),
        .cin  (carry_q),
        .sum  (dig_sum),
        .cout (dig_cout)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (tick && !game_over_q) state_d = StCapture;
            StCapture: state_d = StCompare;
            StCompare: state_d = overlap ? StScore : StIdle;
            StScore:   if (digit_idx_q == 2'd3) state_d = StLevel;
            StLevel:   state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            vblnk_q     <= 1'b0;
            mx_q        <= '0;
            my_q        <= '0;
            ex_q        <= '0;
            ey_q        <= '0;
            on_q        <= 1'b0;
            alive_q     <= 1'b0;
            digit_idx_q <= '0;
            carry_q     <= 1'b0;
            sat_q       <= 1'b0;
            score_q     <= '0;
            hit_q       <= 1'b0;
            level_q     <= 4'd1;
            level_up_q  <= 1'b0;
            hit_cnt_q   <= '0;
        end else begin
            vblnk_q    <= vblnk;
            hit_q      <= 1'b0;
            level_up_q <= 1'b0;
            case (state_q)
                StCapture: begin
                    mx_q    <= missile_x;
                    my_q    <= missile_y;
                    ex_q    <= enemy_x;
                    ey_q    <= enemy_y;
                    on_q    <= missile_on;
                    alive_q <= enemy_alive;
                end
                StCompare: begin
                    hit_q       <= overlap;
                    digit_idx_q <= '0;
                    carry_q     <= 1'b0;
                    // BCD ordering matches numeric ordering, so a plain compare works.
                    sat_q       <= score_q > (MAX_SCORE_BCD - 16'(POINTS));
                end
                StScore: begin
                    if (sat_q) begin
                        score_q <= MAX_SCORE_BCD;
                    end else begin
                        score_q[{digit_idx_q, 2'b00} +: 4] <= dig_sum;
                    end
                    carry_q     <= dig_cout;
                    digit_idx_q <= digit_idx_q + 2'd1;
                end
                StLevel: begin
                    if (hit_cnt_q == CntW'(HITS_PER_LEVEL - 1)) begin
                        hit_cnt_q <= '0;
                        if (level_q < 4'(MAX_LEVEL)) begin
                            level_q    <= level_q + 4'd1;
                            level_up_q <= 1'b1;
                        end
                    end else begin
                        hit_cnt_q <= hit_cnt_q + CntW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef HIT_SCORE_LIVES_EN
    always_ff @(posedge pclk) begin
        if (rst) begin
            lives_q     <= 2'd3;
            game_over_q <= 1'b0;
        end else begin
            if (player_hit && (lives_q != 2'd0)) lives_q <= lives_q - 2'd1;
            // Sets the cycle after lives has reached zero; sticky until reset.
            if (lives_q == 2'd0) game_over_q <= 1'b1;
        end
    end
`else
    logic unused_player_hit;
    assign unused_player_hit = player_hit;
    assign lives_q     = 2'd3;
    assign game_over_q = 1'b0;
`endif

    assign hit       = hit_q;
    assign score_bcd = score_q;
    assign level     = level_q;
    assign level_up  = level_up_q;
    assign lives     = lives_q;
    assign game_over = game_over_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_hit_score_ctl.sv
module tb_hit_score_ctl;

    logic        pclk;
    logic        rst;
    logic        vblnk;
    logic [11:0] missile_x, missile_y, enemy_x, enemy_y;
    logic        missile_on, enemy_alive, player_hit;
    logic        hit, level_up, game_over, busy;
    logic [15:0] score_bcd;
    logic [3:0]  level;
    logic [1:0]  lives;

    hit_score_ctl dut (
        .pclk        (pclk),
        .rst         (rst),
        .vblnk       (vblnk),
        .missile_x   (missile_x),
        .missile_y   (missile_y),
        .missile_on  (missile_on),
        .enemy_x     (enemy_x),
        .enemy_y     (enemy_y),
        .enemy_alive (enemy_alive),
        .player_hit  (player_hit),
        .hit         (hit),
        .score_bcd   (score_bcd),
        .level       (level),
        .level_up    (level_up),
        .lives       (lives),
        .game_over   (game_over),
        .busy        (busy)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic        hit;
        logic [15:0] score;
        logic [3:0]  level;
        logic        level_up;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    // Reference model state
    int   m_score;
    int   m_level;
    int   m_cnt;
    int   m_ups;
    logic m_go;
    int   dut_ups;

    function automatic logic [15:0] to_bcd(input int v);
        to_bcd = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic model_reset();
        m_score = 0;
        m_level = 1;
        m_cnt   = 0;
        m_go    = 1'b0;
    endtask

    task automatic do_frame(input int mx, input int my, input logic on,
                            input int ex, input int ey, input logic alive);
        logic ov;
        exp_t e, got;
        int   hits;
        int   ups;
        logic hit3, lu8, busy8;
        logic [15:0] score7;
        ov = (mx < ex + 64) && (mx + 4 > ex) && (my < ey + 48) && (my + 16 > ey)
             && on && alive && !m_go;
        e.hit = ov;
        e.level_up = 1'b0;
        if (ov) begin
            m_score = (m_score + 5 > 9999) ? 9999 : m_score + 5;
            m_cnt++;
            if (m_cnt == 8) begin
                m_cnt = 0;
                if (m_level < 9) begin
                    m_level++;
                    m_ups++;
                    e.level_up = 1'b1;
                end
            end
        end
        e.score = to_bcd(m_score);
        e.level = 4'(m_level);
        sb.push_back(e);

        missile_x = 12'(mx); missile_y = 12'(my); missile_on = on;
        enemy_x = 12'(ex); enemy_y = 12'(ey); enemy_alive = alive;
        vblnk = 1'b1;
        hits = 0; ups = 0; hit3 = 1'b0; lu8 = 1'b0; busy8 = 1'b1; score7 = '0;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (hit) hits++;
            if (level_up) ups++;
            if (k == 3) hit3 = hit;
            if (k == 7) score7 = score_bcd;
            if (k == 8) begin lu8 = level_up; busy8 = busy; end
        end
        vblnk = 1'b0;
        step();
        dut_ups += ups;

        got = sb.pop_front();
        n_checks++;
        if (hit3 !== got.hit) begin
            n_fails++;
            $display("FAIL hit_at_T3: got %b expected %b (mx=%0d)", hit3, got.hit, mx);
        end
        n_checks++;
        if (hits !== (got.hit ? 1 : 0)) begin
            n_fails++;
            $display("FAIL hit_pulse_count: got %0d expected %0d", hits, got.hit ? 1 : 0);
        end
        if (got.hit) begin
            n_checks++;
            if (score7 !== got.score) begin
                n_fails++;
                $display("FAIL score_at_T7: got %h expected %h", score7, got.score);
            end
        end
        n_checks++;
        if (score_bcd !== got.score) begin
            n_fails++;
            $display("FAIL score: got %h expected %h", score_bcd, got.score);
        end
        n_checks++;
        if (level !== got.level) begin
            n_fails++;
            $display("FAIL level: got %0d expected %0d", level, got.level);
        end
        n_checks++;
        if (lu8 !== got.level_up || ups !== (got.level_up ? 1 : 0)) begin
            n_fails++;
            $display("FAIL level_up: got T8=%b count=%0d expected %b", lu8, ups, got.level_up);
        end
        n_checks++;
        if (busy8 !== 1'b0) begin
            n_fails++;
            $display("FAIL busy_at_T8: got %b expected 0", busy8);
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++;
        if (score_bcd !== 16'h0000 || level !== 4'd1 || hit !== 1'b0 || level_up !== 1'b0
            || lives !== 2'd3 || game_over !== 1'b0 || busy !== 1'b0) begin
            n_fails++;
            $display("FAIL %s: got score=%h level=%0d hit=%b lu=%b lives=%0d go=%b busy=%b expected 0000 1 0 0 3 0 0",
                     tag, score_bcd, level, hit, level_up, lives, game_over, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; vblnk = 1'b0; player_hit = 1'b0;
        missile_x = '0; missile_y = '0; missile_on = 1'b0;
        enemy_x = '0; enemy_y = '0; enemy_alive = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        model_reset();
        m_ups = 0;
        dut_ups = 0;
        check_reset_values("reset_state");
    endtask

    task automatic test_basic_hit();
        do_frame(300, 400, 1'b1, 280, 380, 1'b1);
    endtask

    task automatic test_miss();
        do_frame(400, 400, 1'b1, 280, 380, 1'b1);
        do_frame(300, 400, 1'b0, 280, 380, 1'b1);
        do_frame(300, 400, 1'b1, 280, 380, 1'b0);
    endtask

    task automatic test_edge();
        do_frame(344, 400, 1'b1, 280, 380, 1'b1);
        do_frame(343, 400, 1'b1, 280, 380, 1'b1);
        do_frame(276, 400, 1'b1, 280, 380, 1'b1);
        do_frame(277, 364, 1'b1, 280, 380, 1'b1);
    endtask

    task automatic test_levels_and_saturation();
        while (m_score < 9995) do_frame(300, 400, 1'b1, 280, 380, 1'b1);
        do_frame(300, 400, 1'b1, 280, 380, 1'b1);
        do_frame(300, 400, 1'b1, 280, 380, 1'b1);
        n_checks++;
        if (dut_ups !== m_ups) begin
            n_fails++;
            $display("FAIL level_up_total: got %0d expected %0d", dut_ups, m_ups);
        end
    endtask

    task automatic test_reset_mid_score();
        missile_x = 12'd300; missile_y = 12'd400; missile_on = 1'b1;
        enemy_x = 12'd280; enemy_y = 12'd380; enemy_alive = 1'b1;
        vblnk = 1'b1;
        repeat (4) step();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fails++;
            $display("FAIL busy_in_score: got %b expected 1", busy);
        end
        rst = 1'b1;
        step();
        check_reset_values("reset_mid_score");
        rst = 1'b0;
        vblnk = 1'b0;
        step();
        model_reset();
    endtask

    task automatic test_lives();
`ifdef HIT_SCORE_LIVES_EN
        for (int i = 0; i < 3; i++) begin
            player_hit = 1'b1; step();
            player_hit = 1'b0; step();
        end
        step();
        n_checks++;
        if (lives !== 2'd0 || game_over !== 1'b1) begin
            n_fails++;
            $display("FAIL lives_game_over: got lives=%0d go=%b expected 0 1", lives, game_over);
        end
        m_go = 1'b1;
        do_frame(300, 400, 1'b1, 280, 380, 1'b1);
        do_frame(300, 400, 1'b1, 280, 380, 1'b1);
        rst = 1'b1; step(); rst = 1'b0; step();
        model_reset();
        check_reset_values("reset_after_game_over");
`else
        player_hit = 1'b1; step();
        player_hit = 1'b0; step(); step();
        n_checks++;
        if (lives !== 2'd3 || game_over !== 1'b0) begin
            n_fails++;
            $display("FAIL lives_disabled: got lives=%0d go=%b expected 3 0", lives, game_over);
        end
        do_frame(300, 400, 1'b1, 280, 380, 1'b1);
`endif
    endtask

    initial begin
        test_reset();
        test_basic_hit();
        test_miss();
        test_edge();
        test_levels_and_saturation();
        test_reset_mid_score();
        test_lives();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
